// File: rtl/mult_datapath.sv
// Shift-add 32x32 unsigned multiplier datapath driven by an external FSM.
// Optional sticky select-error flag under `ifdef MULT_DP_ERR_EN.
//
// Ports:
//   clk     in   1   rising-edge clock
//   reset   in   1   synchronous active-high reset
//   mcand   in  32   multiplicand, loaded when B_sel=01
//   mplier  in  32   multiplier, loaded when Q_sel=01
//   B_sel   in   2   B control: 00 hold, 01 load, 1x hold
//   Q_sel   in   2   Q control: 00 hold, 01 load, 10 shift, 11 hold
//   A_sel   in   2   A control: 00 hold, 01 clear, 10 add B, 11 shift
//   N_sel   in   2   N control: 00 hold, 01 load 32, 10 dec, 11 hold
//   Qsub0   out  1   Q[0]
//   N_EQ_0  out  1   N == 0
//   product out 64   {A,Q}
//   sel_err out  1   sticky reserved-code / N underflow flag
//                    (only with MULT_DP_ERR_EN defined)
module mult_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
  input  logic [1:0]  B_sel,
  input  logic [1:0]  Q_sel,
  input  logic [1:0]  A_sel,
  input  logic [1:0]  N_sel,
  output logic        Qsub0,
  output logic        N_EQ_0,
  output logic [63:0] product
`ifdef MULT_DP_ERR_EN
  ,
  output logic        sel_err
`endif
);

  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_q;
  logic        r_c;
  logic [5:0]  r_n;

  logic [32:0] w_sum;
  logic        w_n_zero;

  assign w_sum    = {1'b0, r_a} + {1'b0, r_b};
  assign w_n_zero = (r_n == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_q <= '0;
      r_c <= 1'b0;
      r_n <= '0;
    end else begin
      if (B_sel == 2'b01)
        r_b <= mcand;

      case (A_sel)
        2'b01: begin
          r_a <= '0;
          r_c <= 1'b0;
        end
        2'b10: begin
          // carry parks in C until the following shift
          r_a <= w_sum[31:0];
          r_c <= w_sum[32];
        end
        2'b11: begin
          r_a <= {r_c, r_a[31:1]};
          r_c <= 1'b0;
        end
        default: ;
      endcase

      case (Q_sel)
        2'b01:   r_q <= mplier;
        // pre-edge A[0] keeps {C,A,Q} a single shifter
        2'b10:   r_q <= {r_a[0], r_q[31:1]};
        default: ;
      endcase

      case (N_sel)
        2'b01:   r_n <= 6'd32;
        2'b10:   if (!w_n_zero) r_n <= r_n - 6'd1;
        default: ;
      endcase
    end
  end

`ifdef MULT_DP_ERR_EN
  logic r_err;
  logic w_err_hit;

  assign w_err_hit = B_sel[1]
                   | (Q_sel == 2'b11)
                   | (N_sel == 2'b11)
                   | ((N_sel == 2'b10) & w_n_zero);

  always_ff @(posedge clk) begin
    if (reset)
      r_err <= 1'b0;
    else if (w_err_hit)
      r_err <= 1'b1;
  end

  assign sel_err = r_err;
`endif

  assign Qsub0   = r_q[0];
  assign N_EQ_0  = w_n_zero;
  assign product = {r_a, r_q};

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath.
// Fixed scenarios, random multiplies and random select sequences.
module tb_mult_datapath;

  logic        clk;
  logic        reset;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic [1:0]  B_sel;
  logic [1:0]  Q_sel;
  logic [1:0]  A_sel;
  logic [1:0]  N_sel;
  logic        Qsub0;
  logic        N_EQ_0;
  logic [63:0] product;
`ifdef MULT_DP_ERR_EN
  logic        sel_err;
`endif

  int total;
  int bad;

  mult_datapath dut (
    .clk     (clk),
    .reset   (reset),
    .mcand   (mcand),
    .mplier  (mplier),
    .B_sel   (B_sel),
    .Q_sel   (Q_sel),
    .A_sel   (A_sel),
    .N_sel   (N_sel),
    .Qsub0   (Qsub0),
    .N_EQ_0  (N_EQ_0),
    .product (product)
`ifdef MULT_DP_ERR_EN
    ,
    .sel_err (sel_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] b, input logic [1:0] q,
                       input logic [1:0] a, input logic [1:0] n);
    B_sel = b;
    Q_sel = q;
    A_sel = a;
    N_sel = n;
    @(posedge clk);
    #1;
  endtask

  task automatic run_mult(input logic [31:0] mc, input logic [31:0] mp,
                          input int iters);
    mcand  = mc;
    mplier = mp;
    drive(2'b01, 2'b01, 2'b01, 2'b01);
    for (int i = 0; i < iters; i++) begin
      drive(2'b00, 2'b00, Qsub0 ? 2'b10 : 2'b00, 2'b00);
      drive(2'b00, 2'b10, 2'b11, 2'b10);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(2'b01, 2'b01, 2'b10, 2'b01);
    reset = 1'b0;
    total++;
    if (product !== 64'd0) begin
      bad++;
      $display("FAIL reset_product got=%h want=0", product);
    end
    total++;
    if (Qsub0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_qsub0 got=%b want=0", Qsub0);
    end
    total++;
    if (N_EQ_0 !== 1'b1) begin
      bad++;
      $display("FAIL reset_neq0 got=%b want=1", N_EQ_0);
    end
`ifdef MULT_DP_ERR_EN
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_selerr got=%b want=0", sel_err);
    end
`endif
  endtask

  task automatic test_small();
    mcand  = 32'd3;
    mplier = 32'd5;
    drive(2'b01, 2'b01, 2'b01, 2'b01);
    total++;
    if (N_EQ_0 !== 1'b0) begin
      bad++;
      $display("FAIL small_loaded_neq0 got=%b want=0", N_EQ_0);
    end
    for (int i = 0; i < 32; i++) begin
      drive(2'b00, 2'b00, Qsub0 ? 2'b10 : 2'b00, 2'b00);
      drive(2'b00, 2'b10, 2'b11, 2'b10);
      if (i == 30) begin
        total++;
        if (N_EQ_0 !== 1'b0) begin
          bad++;
          $display("FAIL small_neq0_early got=%b want=0", N_EQ_0);
        end
      end
    end
    total++;
    if (product !== 64'd15) begin
      bad++;
      $display("FAIL small_product got=%0d want=15", product);
    end
    total++;
    if (N_EQ_0 !== 1'b1) begin
      bad++;
      $display("FAIL small_neq0 got=%b want=1", N_EQ_0);
    end
  endtask

  task automatic test_max();
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    total++;
    if (product !== 64'hFFFF_FFFE_0000_0001) begin
      bad++;
      $display("FAIL max_product got=%h want=fffffffe00000001",
               product);
    end
  endtask

  task automatic test_zero_mplier();
    int errs;
    errs   = 0;
    mcand  = 32'h1234_5678;
    mplier = 32'd0;
    drive(2'b01, 2'b01, 2'b01, 2'b01);
    for (int i = 0; i < 32; i++) begin
      drive(2'b00, 2'b00, Qsub0 ? 2'b10 : 2'b00, 2'b00);
      if (Qsub0 !== 1'b0 || product[63:32] !== 32'd0) errs++;
      drive(2'b00, 2'b10, 2'b11, 2'b10);
      if (Qsub0 !== 1'b0 || product[63:32] !== 32'd0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL zero_trace got=%0d bad cycles want=0", errs);
    end
    total++;
    if (product !== 64'd0) begin
      bad++;
      $display("FAIL zero_product got=%h want=0", product);
    end
  endtask

  task automatic test_mid_reset();
    run_mult(32'd3, 32'd5, 10);
    reset = 1'b1;
    drive(2'b01, 2'b10, 2'b10, 2'b10);
    reset = 1'b0;
    total++;
    if (product !== 64'd0) begin
      bad++;
      $display("FAIL midrst_product got=%h want=0", product);
    end
    total++;
    if (N_EQ_0 !== 1'b1) begin
      bad++;
      $display("FAIL midrst_neq0 got=%b want=1", N_EQ_0);
    end
    run_mult(32'd7, 32'd9, 32);
    total++;
    if (product !== 64'd63) begin
      bad++;
      $display("FAIL midrst_reload got=%0d want=63", product);
    end
  endtask

  task automatic test_saturate();
    run_mult(32'd2, 32'd4, 32);
`ifdef MULT_DP_ERR_EN
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("FAIL sat_selerr_pre got=%b want=0", sel_err);
    end
`endif
    drive(2'b00, 2'b00, 2'b00, 2'b10);
    total++;
    if (N_EQ_0 !== 1'b1) begin
      bad++;
      $display("FAIL sat_neq0 got=%b want=1", N_EQ_0);
    end
    total++;
    if (product !== 64'd8) begin
      bad++;
      $display("FAIL sat_product got=%0d want=8", product);
    end
`ifdef MULT_DP_ERR_EN
    total++;
    if (sel_err !== 1'b1) begin
      bad++;
      $display("FAIL sat_selerr got=%b want=1", sel_err);
    end
    drive(2'b00, 2'b00, 2'b00, 2'b01);
    drive(2'b00, 2'b00, 2'b00, 2'b00);
    total++;
    if (sel_err !== 1'b1) begin
      bad++;
      $display("FAIL sat_selerr_sticky got=%b want=1", sel_err);
    end
    do_reset();
    total++;
    if (sel_err !== 1'b0) begin
      bad++;
      $display("FAIL sat_selerr_clr got=%b want=0", sel_err);
    end
`endif
  endtask

  task automatic test_random_mult();
    logic [31:0] mc;
    logic [31:0] mp;
    logic [63:0] exp;
    for (int k = 0; k < 20; k++) begin
      mc  = $urandom;
      mp  = $urandom;
      if (k == 0) mp = 32'h8000_0001;
      exp = 64'(mc) * 64'(mp);
      run_mult(mc, mp, 32);
      total++;
      if (product !== exp) begin
        bad++;
        $display("FAIL rand_mult %h*%h got=%h want=%h",
                 mc, mp, product, exp);
      end
    end
  endtask

  task automatic test_random_sel();
    logic [31:0] ma, mb, mq, na, nb, nq;
    logic        mc, nc;
    logic [32:0] s;
    logic [63:0] w;
    int          mn, nn;
    logic        merr;
    logic [1:0]  bs, qs, as, ns;
    do_reset();
    ma = 0; mb = 0; mq = 0; mc = 0; mn = 0; merr = 0;
    for (int k = 0; k < 300; k++) begin
      bs = 2'($urandom_range(0, 3));
      qs = 2'($urandom_range(0, 3));
      as = 2'($urandom_range(0, 3));
      ns = 2'($urandom_range(0, 3));
      mcand  = $urandom;
      mplier = $urandom;
      nb = (bs == 2'd1) ? mcand : mb;
      na = ma;
      nc = mc;
      if (as == 2'd1) begin
        na = 0;
        nc = 0;
      end else if (as == 2'd2) begin
        s  = 33'(ma) + 33'(mb);
        na = s[31:0];
        nc = s[32];
      end else if (as == 2'd3) begin
        s  = {mc, ma} >> 1;
        na = s[31:0];
        nc = 0;
      end
      nq = mq;
      if (qs == 2'd1) begin
        nq = mplier;
      end else if (qs == 2'd2) begin
        w  = {ma, mq} >> 1;
        nq = w[31:0];
      end
      nn = mn;
      if (ns == 2'd1) nn = 32;
      else if (ns == 2'd2) nn = (mn > 0) ? mn - 1 : 0;
      if (bs >= 2'd2 || qs == 2'd3 || ns == 2'd3 ||
          (ns == 2'd2 && mn == 0))
        merr = 1'b1;
      drive(bs, qs, as, ns);
      ma = na; mb = nb; mq = nq; mc = nc; mn = nn;
      total++;
      if (product !== {ma, mq} || Qsub0 !== mq[0] ||
          N_EQ_0 !== (mn == 0)) begin
        bad++;
        $display("FAIL rand_sel k=%0d got=%h/%b/%b want=%h/%b/%b",
                 k, product, Qsub0, N_EQ_0, {ma, mq}, mq[0],
                 (mn == 0));
      end
`ifdef MULT_DP_ERR_EN
      total++;
      if (sel_err !== merr) begin
        bad++;
        $display("FAIL rand_selerr k=%0d got=%b want=%b",
                 k, sel_err, merr);
      end
`endif
    end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    mcand  = '0;
    mplier = '0;
    B_sel  = '0;
    Q_sel  = '0;
    A_sel  = '0;
    N_sel  = '0;
    #2;
    test_reset();
    test_small();
    test_max();
    test_zero_mplier();
    test_mid_reset();
    test_saturate();
    test_random_mult();
    test_random_sel();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
